// File: rtl/fc_out_stage.sv
// fc_out_stage: fully-connected output stage.
// Takes a snapshot of CH signed accumulators on start, then streams one channel
// per cycle through bias-add / arithmetic shift / saturate / optional ReLU and
// writes the results into a buffer read with 2-cycle latency.
//
// Control protocol: start is a single-cycle request that is accepted only while
// busy=0 (ignored otherwise). An accepted start raises busy on the next edge;
// done pulses for one cycle when the last result is in the buffer, in the same
// cycle busy drops, and a new start may be accepted in that cycle.
module fc_out_stage #(
    parameter int CH    = 84,
    parameter int ACC_W = 23,
    parameter int DW    = 16,
    parameter int SHIFT = 0,
    parameter int AW    = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [CH*ACC_W-1:0]   acc_in,
    input  logic                  b_we,
    input  logic [AW-1:0]         b_waddr,
    input  logic [DW-1:0]         b_wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    output logic [1:0]            dbg_state
);

    // Sum width: one guard bit above the accumulator so acc + bias never wraps.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q;
    logic [AW-1:0]             idx_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      relu_q;
    logic                      sat_q;
    logic signed [ACC_W-1:0]   snap_q [CH];
    logic signed [DW-1:0]      bias_q [CH];
    logic [DW-1:0]             res_q  [CH];

    logic                      v1_q;
    logic [AW-1:0]             idx1_q;
    logic signed [SW-1:0]      sh1_q;

    logic [AW-1:0]             raddr_q;
    logic [DW-1:0]             rdata_q;

    logic                      start_acc;
    logic signed [SW-1:0]      acc_x;
    logic signed [SW-1:0]      bias_x;
    logic signed [SW-1:0]      sum_d;
    logic signed [SW-1:0]      sh_d;
    logic [DW-1:0]             res_d;
    logic                      sat_d;

    assign start_acc = (state_q == ST_IDLE) && start;

    // Control FSM: run sequencing, busy/done, latched relu mode and sticky saturation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            relu_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (v1_q && sat_d) begin
                sat_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        relu_q  <= relu_en;
                        sat_q   <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == AW'(CH - 1)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot of all accumulators, taken only when a start is accepted.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            for (int k = 0; k < CH; k++) begin
                snap_q[k] <= acc_in[k*ACC_W +: ACC_W];
            end
        end
    end

    // Bias registers; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                bias_q[k] <= '0;
            end
        end else if (b_we && ({1'b0, b_waddr} < (AW + 1)'(CH))) begin
            bias_q[b_waddr] <= b_wdata;
        end
    end

    // Stage 1 datapath: sign-extend, add bias, arithmetic shift.
    always_comb begin
        acc_x  = {snap_q[idx_q][ACC_W-1], snap_q[idx_q]};
        bias_x = {{(SW - DW){bias_q[idx_q][DW-1]}}, bias_q[idx_q]};
        sum_d  = acc_x + bias_x;
        sh_d   = sum_d >>> SHIFT;
    end

    // Stage 1 register: shifted sum plus its channel index and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            idx1_q <= '0;
            sh1_q  <= '0;
        end else begin
            v1_q   <= (state_q == ST_RUN);
            idx1_q <= idx_q;
            sh1_q  <= sh_d;
        end
    end

    // Stage 2 datapath: saturate to DW bits, then ReLU on the saturated value.
    always_comb begin
        res_d = sh1_q[DW-1:0];
        sat_d = 1'b0;
        if (sh1_q > MAX_V) begin
            res_d = MAX_V[DW-1:0];
            sat_d = 1'b1;
        end else if (sh1_q < MIN_V) begin
            res_d = MIN_V[DW-1:0];
            sat_d = 1'b1;
        end
        if (relu_q && res_d[DW-1]) begin
            res_d = '0;
        end
    end

    // Result buffer write from stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                res_q[k] <= '0;
            end
        end else if (v1_q) begin
            res_q[idx1_q] <= res_d;
        end
    end

    // Registered read port: address stage then data stage; out-of-range reads give 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            raddr_q <= raddr;
            if ({1'b0, raddr_q} < (AW + 1)'(CH)) begin
                rdata_q <= res_q[raddr_q];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_flag  = sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_out_stage.sv
// Testbench for fc_out_stage: table of single-channel vectors plus directed
// multi-cycle sequences (ignored restart, mid-run bias writes, mid-run reset).
module tb_fc_out_stage;

    localparam int CH    = 84;
    localparam int ACC_W = 23;
    localparam int DW    = 16;
    localparam int AW    = 7;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                relu_en;
    logic [CH*ACC_W-1:0] acc_in;
    logic                b_we;
    logic [AW-1:0]       b_waddr;
    logic [DW-1:0]       b_wdata;
    logic [AW-1:0]       raddr;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic                done;
    logic                sat_flag;
    logic [1:0]          dbg_state;

    fc_out_stage #(.CH(CH), .ACC_W(ACC_W), .DW(DW), .SHIFT(0), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .relu_en   (relu_en),
        .acc_in    (acc_in),
        .b_we      (b_we),
        .b_waddr   (b_waddr),
        .b_wdata   (b_wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       ch;
        int       acc;
        int       bias;
        bit       relu;
        logic [15:0] exp;
        bit       exp_sat;
    } vec_t;

    vec_t        vecs [12];
    logic [DW-1:0] exp_res [CH];
    int          n_checks;
    int          n_pass;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic write_bias(input int a, input int v);
        b_we    = 1'b1;
        b_waddr = AW'(a);
        b_wdata = DW'(v);
        tick;
        b_we    = 1'b0;
    endtask

    task automatic rd(input int a, output logic [DW-1:0] d);
        raddr = AW'(a);
        tick;
        tick;
        d = rdata;
    endtask

    task automatic model_clear;
        for (int k = 0; k < CH; k++) exp_res[k] = '0;
    endtask

    // Back-to-back reads of every address; data for address i-1 appears two edges after it was presented.
    task automatic sweep(input string name);
        for (int i = 0; i <= CH; i++) begin
            raddr = (i < CH) ? AW'(i) : AW'(0);
            tick;
            if (i >= 1) check($sformatf("%s[%0d]", name, i - 1), 32'(rdata), 32'(exp_res[i-1]));
        end
    endtask

    // Start a run and wait (bounded) for done. mode: 0 plain, 1 restart attempts + relu/acc
    // disturbance, 2 mid-run bias writes, 3 reset at cycle 20.
    task automatic run(input bit relu, input int mode, output int cyc, output int busy_cyc,
                       output bit saw_done, output bit done_after, output bit rst_busy);
        start   = 1'b1;
        relu_en = relu;
        tick;
        start   = 1'b0;
        relu_en = 1'b0;
        cyc = 0;
        busy_cyc = busy ? 1 : 0;
        saw_done = 1'b0;
        done_after = 1'b0;
        rst_busy = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            start = 1'b0;
            b_we  = 1'b0;
            rst_n = 1'b1;
            relu_en = 1'b0;
            if (mode == 1) begin
                if (c == 10) begin
                    start = 1'b1;
                    relu_en = 1'b1;
                    acc_in[3*ACC_W +: ACC_W] = ACC_W'(5000);
                end
                if (c == 40) start = 1'b1;
                if (c >= 20 && c <= 30) relu_en = 1'b1;
            end else if (mode == 2) begin
                if (c == 3) begin
                    b_we = 1'b1; b_waddr = AW'(83); b_wdata = 16'h0123;
                end
                if (c == 6) begin
                    b_we = 1'b1; b_waddr = AW'(5); b_wdata = 16'h0050;
                end
            end else if (mode == 3) begin
                if (c == 20) rst_n = 1'b0;
            end
            tick;
            if (mode == 3 && c == 20) rst_busy = busy;
            if (busy) busy_cyc++;
            if (done) begin
                saw_done = 1'b1;
                cyc = c;
                break;
            end
        end
        start = 1'b0;
        b_we  = 1'b0;
        rst_n = 1'b1;
        relu_en = 1'b0;
        if (saw_done) begin
            tick;
            done_after = done;
        end
    endtask

    task automatic run_checked(input bit relu, input int mode, input string name);
        int cyc, bc;
        bit sd, da, rb;
        run(relu, mode, cyc, bc, sd, da, rb);
        check({name, "_done_cycle"}, 32'(cyc), 32'(CH + 1));
        check({name, "_busy_cycles"}, 32'(bc), 32'(CH + 1));
        check({name, "_done_pulse"}, 32'(da), 32'(0));
    endtask

    initial begin
        logic [DW-1:0] d;
        int cyc, bc;
        bit sd, da, rb;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        relu_en  = 1'b0;
        acc_in   = '0;
        b_we     = 1'b0;
        b_waddr  = '0;
        b_wdata  = '0;
        raddr    = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_sat", 32'(sat_flag), 32'(0));
        check("reset_rdata", 32'(rdata), 32'(0));

        //              ch  acc        bias     relu  exp       sat
        vecs[0]  = '{0,  1000,      'h0675,  1'b0, 16'h0A5D, 1'b0};
        vecs[1]  = '{5,  'h3FFFFF,  'h7FFF,  1'b0, 16'h7FFF, 1'b1};
        vecs[2]  = '{5,  -4194304,  'h8000,  1'b0, 16'h8000, 1'b1};
        vecs[3]  = '{3,  -500,      100,     1'b0, 16'hFE70, 1'b0};
        vecs[4]  = '{3,  -500,      100,     1'b1, 16'h0000, 1'b0};
        vecs[5]  = '{83, 32767,     0,       1'b0, 16'h7FFF, 1'b0};
        vecs[6]  = '{83, 32768,     0,       1'b0, 16'h7FFF, 1'b1};
        vecs[7]  = '{10, -32768,    0,       1'b0, 16'h8000, 1'b0};
        vecs[8]  = '{10, -32769,    0,       1'b0, 16'h8000, 1'b1};
        vecs[9]  = '{20, -4194304,  'h8000,  1'b1, 16'h0000, 1'b1};
        vecs[10] = '{1,  100,       5,       1'b1, 16'h0069, 1'b0};
        vecs[11] = '{42, 30000,     'h7FFF,  1'b0, 16'h7FFF, 1'b1};

        for (int i = 0; i < 12; i++) begin
            write_bias(vecs[i].ch, vecs[i].bias);
            acc_in = '0;
            acc_in[vecs[i].ch*ACC_W +: ACC_W] = ACC_W'(vecs[i].acc);
            run_checked(vecs[i].relu, 0, $sformatf("vec%0d", i));
            rd(vecs[i].ch, d);
            check($sformatf("vec%0d_result", i), 32'(d), 32'(vecs[i].exp));
            check($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(vecs[i].exp_sat));
            if (i == 0) begin
                model_clear;
                exp_res[0] = 16'h0A5D;
                sweep("basic_sweep");
                rd(90, d);
                check("raddr_out_of_range", 32'(d), 32'(0));
            end
            write_bias(vecs[i].ch, 0);
        end

        // Restart attempts mid-run, relu toggling and acc_in changes must not disturb the run.
        write_bias(3, 100);
        acc_in = '0;
        acc_in[3*ACC_W +: ACC_W] = ACC_W'(-500);
        run_checked(1'b0, 1, "restart_ignored");
        rd(3, d);
        check("restart_ignored_result", 32'(d), 32'(16'hFE70));
        write_bias(3, 0);

        // Bias write well before issue is used; write on the issue edge uses the old bias.
        acc_in = '0;
        run_checked(1'b0, 2, "midrun_bias");
        rd(83, d);
        check("midrun_bias_ch83", 32'(d), 32'(16'h0123));
        rd(5, d);
        check("same_edge_bias_ch5_old", 32'(d), 32'(0));
        run_checked(1'b0, 0, "bias_landed");
        rd(5, d);
        check("bias_landed_ch5", 32'(d), 32'(16'h0050));
        rd(83, d);
        check("bias_landed_ch83", 32'(d), 32'(16'h0123));
        write_bias(5, 0);
        write_bias(83, 0);

        // Write to an address beyond the last channel changes nothing.
        write_bias(84, 'h1234);
        run_checked(1'b0, 0, "bad_waddr");
        model_clear;
        sweep("bad_waddr_sweep");

        // Reset in the middle of a run with live data in the buffer and a nonzero bias.
        write_bias(7, 'h0042);
        acc_in = '0;
        acc_in[0 +: ACC_W] = ACC_W'(1000);
        run(1'b0, 3, cyc, bc, sd, da, rb);
        check("midrun_reset_no_done", 32'(sd), 32'(0));
        check("midrun_reset_busy", 32'(rb), 32'(0));
        check("midrun_reset_busy_end", 32'(busy), 32'(0));
        check("midrun_reset_sat", 32'(sat_flag), 32'(0));
        model_clear;
        sweep("reset_sweep");
        acc_in = '0;
        run_checked(1'b0, 0, "post_reset");
        rd(7, d);
        check("post_reset_bias_cleared", 32'(d), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_out_stage.md
# fc_out_stage

Parametrised fully-connected output stage for the LeNet datapath. It takes one snapshot of CH signed MAC accumulators on a start pulse and runs the values through a single shared pipeline, one channel per cycle. The pipeline adds a runtime-loadable bias, arithmetically shifts, saturates and optionally applies ReLU. Results land in an addressable buffer read by the next layer with 2-cycle latency. It replaces the fixed 84-channel, hard-coded-bias FC output blocks.

## Interface
- CH, 84, number of channels (neurons)
- ACC_W, 23, accumulator width (signed)
- DW, 16, bias and result width (signed)
- SHIFT, 0, arithmetic right shift applied after bias add (0..ACC_W-1)
- AW, $clog2(CH), address width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: capture acc_in and begin a run
- relu_en  in  1  sampled with start; 1 = clamp negative results to 0 for the whole run
- acc_in  in  CH*ACC_W  flattened accumulators, channel k at [k*ACC_W +: ACC_W]
- b_we  in  1  bias write enable
- b_waddr  in  AW  bias write address
- b_wdata  in  DW  bias value (signed)
- raddr  in  AW  result read address
- rdata  out  DW  result read data
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the last result is written
- sat_flag  out  1  sticky: some channel saturated in the current/last run

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 captures all CH accumulators into a snapshot register, latches relu_en, clears sat_flag, clears idx to 0, sets busy, and moves to RUN.
- RUN: issues channel idx into stage 1, then increments idx. After issuing idx=CH-1 the FSM moves to DRAIN.
- DRAIN: waits one cycle for stage 2 to write the last channel. It then pulses done, drops busy, and returns to IDLE.
- start while busy=1 is ignored. The snapshot and relu mode stay unchanged.
- Stage 1: sum = sext(acc[idx], ACC_W+1) + sext(bias[idx], ACC_W+1); sh = sum >>> SHIFT; sh is registered.
- Stage 2:
  - If sh > 2^(DW-1)-1, the result is 2^(DW-1)-1 and sat_flag is set.
  - If sh < -2^(DW-1), the result is -2^(DW-1) and sat_flag is set.
  - If the latched relu is set and the result is negative, the result is 0. A saturated negative value under ReLU still sets sat_flag.
  - The result is written to result[idx_d].
- Bias registers:
  - Written when b_we=1, in any state.
  - A write to channel k during a run takes effect for that run only if it lands before channel k enters stage 1. A same-cycle write and issue uses the old bias.
  - b_waddr >= CH is ignored.
- Results buffer:
  - Holds the previous run's values until each entry is overwritten.
  - A read of an address that is being written in the same cycle returns the old value.
- raddr >= CH returns 0.

## Timing
- Reset (rst_n=0 at an edge) clears the following: FSM to IDLE, busy=0, done=0, sat_flag=0, rdata=0, all bias entries=0, all result entries=0, and the pipeline valid bits.
- Reset mid-run aborts the run. done is not pulsed.
- Start sampled at edge E0:
  - busy=1 after E0.
  - Channel k is written at edge E0+2+k.
  - The last channel is written at edge E0+CH+1.
  - done=1 and busy=0 during the cycle after E0+CH+1.
  - busy is high for exactly CH+1 cycles. A new start is accepted in the same cycle that done is high.
- Read latency is 2: raddr is registered at edge R, array data is registered at edge R+1, and rdata is valid after R+1. rdata is a register output with no combinational path from raddr.
- sat_flag updates at the stage-2 write edge. It holds after done until the next accepted start.

## Test plan
- Basic: CH=84, SHIFT=0, bias[0]=0x0675, acc_in ch0=1000 (all others 0, biases 0), relu_en=0, start → done exactly 85 cycles after start; result[0]=2653 (0x0A5D) and results 1..83 = 0; sat_flag=0.
- Saturation: acc ch5=0x3FFFFF, bias[5]=0x7FFF → rdata@5=0x7FFF and sat_flag=1. Then acc ch5=-4194304 with bias 0x8000 → 0x8000.
- ReLU: acc ch3=-500, bias[3]=100:
  - relu_en=0 → 0xFE70.
  - relu_en=1 → 0x0000.
  - relu_en toggled mid-run has no effect.
- Control:
  - start repeated at cycles 10 and 40 after the first start is ignored, and done comes at 85.
  - A bias write to b_waddr=84 leaves all biases unchanged.
  - A bias write to ch83 at start+3 is used in that run.
- Reset/read:
  - rst_n low at start+20 → busy=0, no done, all reads return 0.
  - raddr=90 → rdata=0 two cycles later.
  - Back-to-back raddr sweep 0..83 returns the stream delayed by 2 cycles.
